// File: rtl/codif_morse_pkg.sv
// codif_morse_pkg -- shared constants, entry type and the ITU Morse lookup
// for the codif_morse encoder.
//
// Contents:
//   NUM_W, SYM_W, MAX_CODE  widths and highest valid character code
//   morse_entry_t           symbol pattern (1 = dash) plus used-position mask
//   morse_lookup()          36-entry table. Codes 0-9 are digits. Codes 10-35 are A-Z.
//                           Any other code returns an all-zero entry.
// Symbols are left-aligned: the first symbol sits at bit SYM_W-1.
package codif_morse_pkg;

    localparam int NUM_W    = 6;
    localparam int SYM_W    = 5;
    localparam int MAX_CODE = 35;

    typedef struct packed {
        logic [SYM_W-1:0] pattern;  // 1 = dash, 0 = dot or unused
        logic [SYM_W-1:0] mask;     // 1 = a symbol exists at this position
    } morse_entry_t;

    function automatic morse_entry_t morse_lookup(input logic [NUM_W-1:0] code);
        morse_entry_t e;
        e = '0;
        case (code)
            // digits: {pattern, mask}
            6'd0:  e = {5'b11111, 5'b11111};  // -----
            6'd1:  e = {5'b01111, 5'b11111};  // .----
            6'd2:  e = {5'b00111, 5'b11111};  // ..---
            6'd3:  e = {5'b00011, 5'b11111};  // ...--
            6'd4:  e = {5'b00001, 5'b11111};  // ....-
            6'd5:  e = {5'b00000, 5'b11111};  // .....
            6'd6:  e = {5'b10000, 5'b11111};  // -....
            6'd7:  e = {5'b11000, 5'b11111};  // --...
            6'd8:  e = {5'b11100, 5'b11111};  // ---..
            6'd9:  e = {5'b11110, 5'b11111};  // ----.
            // letters
            6'd10: e = {5'b01000, 5'b11000};  // A .-
            6'd11: e = {5'b10000, 5'b11110};  // B -...
            6'd12: e = {5'b10100, 5'b11110};  // C -.-.
            6'd13: e = {5'b10000, 5'b11100};  // D -..
            6'd14: e = {5'b00000, 5'b10000};  // E .
            6'd15: e = {5'b00100, 5'b11110};  // F ..-.
            6'd16: e = {5'b11000, 5'b11100};  // G --.
            6'd17: e = {5'b00000, 5'b11110};  // H ....
            6'd18: e = {5'b00000, 5'b11000};  // I ..
            6'd19: e = {5'b01110, 5'b11110};  // J .---
            6'd20: e = {5'b10100, 5'b11100};  // K -.-
            6'd21: e = {5'b01000, 5'b11110};  // L .-..
            6'd22: e = {5'b11000, 5'b11000};  // M --
            6'd23: e = {5'b10000, 5'b11000};  // N -.
            6'd24: e = {5'b11100, 5'b11100};  // O ---
            6'd25: e = {5'b01100, 5'b11110};  // P .--.
            6'd26: e = {5'b11010, 5'b11110};  // Q --.-
            6'd27: e = {5'b01000, 5'b11100};  // R .-.
            6'd28: e = {5'b00000, 5'b11100};  // S ...
            6'd29: e = {5'b10000, 5'b10000};  // T -
            6'd30: e = {5'b00100, 5'b11100};  // U ..-
            6'd31: e = {5'b00010, 5'b11110};  // V ...-
            6'd32: e = {5'b01100, 5'b11100};  // W .--
            6'd33: e = {5'b10010, 5'b11110};  // X -..-
            6'd34: e = {5'b10110, 5'b11110};  // Y -.--
            6'd35: e = {5'b11000, 5'b11110};  // Z --..
            default: e = '0;                  // invalid code: blank
        endcase
        return e;
    endfunction

endpackage

// File: rtl/codif_morse_lamp.sv
// morse_lamp_split -- purely combinational split of a registered Morse
// pattern into dot and dash lamp drives.
//
// Ports:
//   morse   [SYM_W-1:0] in   pattern (1 = dash)
//   display [SYM_W-1:0] in   used-position mask
//   ponto   [SYM_W-1:0] out  dot lamps  = display & ~morse
//   traco   [SYM_W-1:0] out  dash lamps = display &  morse
// Both lamps are gated by display. A position can light as a dot or as a dash, never as both.
module morse_lamp_split
    import codif_morse_pkg::*;
(
    input  logic [SYM_W-1:0] morse,
    input  logic [SYM_W-1:0] display,
    output logic [SYM_W-1:0] ponto,
    output logic [SYM_W-1:0] traco
);

    genvar gi;
    generate
        for (gi = 0; gi < SYM_W; gi++) begin : g_lamp
            assign ponto[gi] = display[gi] & ~morse[gi];
            assign traco[gi] = display[gi] &  morse[gi];
        end
    endgenerate

endmodule

// File: rtl/codif_morse.sv
// codif_morse -- registered character-to-Morse encoder.
//
// On each rising edge where ready=1, the table entry for num is loaded into morse and display.
// The outputs are valid one clock later. Holding ready high reloads the outputs every cycle.
// When ready=0, the outputs hold. An invalid code (num > MAX_CODE) blanks every output.
// reset is synchronous, active-high and has priority over ready.
//
// Ports:
//   clk                  in   clock
//   reset                in   synchronous active-high reset
//   num     [NUM_W-1:0]  in   character code (0-9 digits, 10-35 A-Z)
//   ready                in   load strobe
//   morse   [SYM_W-1:0]  out  pattern, 1 = dash, first symbol at MSB
//   display [SYM_W-1:0]  out  used-position mask
//   ponto   [SYM_W-1:0]  out  dot lamps
//   traco   [SYM_W-1:0]  out  dash lamps
//   err                  out  only when CODIF_MORSE_ERR_EN is defined. Registered.
//                             Set by loading an invalid code and cleared by loading a valid one.
module codif_morse
    import codif_morse_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [NUM_W-1:0] num,
    input  logic             ready,
    output logic [SYM_W-1:0] morse,
    output logic [SYM_W-1:0] display,
    output logic [SYM_W-1:0] ponto,
    output logic [SYM_W-1:0] traco
`ifdef CODIF_MORSE_ERR_EN
    ,
    output logic             err
`endif
);

    morse_entry_t     entry_next;
    logic [SYM_W-1:0] morse_reg;
    logic [SYM_W-1:0] display_reg;

    always_comb begin
        entry_next = morse_lookup(num);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            morse_reg   <= '0;
            display_reg <= '0;
        end else if (ready) begin
            morse_reg   <= entry_next.pattern;
            display_reg <= entry_next.mask;
        end
    end

    assign morse   = morse_reg;
    assign display = display_reg;

    morse_lamp_split u_lamp (
        .morse   (morse_reg),
        .display (display_reg),
        .ponto   (ponto),
        .traco   (traco)
    );

`ifdef CODIF_MORSE_ERR_EN
    logic err_reg;
    logic err_next;

    always_comb begin
        err_next = (num > NUM_W'(MAX_CODE));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_reg <= 1'b0;
        end else if (ready) begin
            err_reg <= err_next;
        end
    end

    assign err = err_reg;
`endif

endmodule

// File: tb/tb_codif_morse.sv
// tb_codif_morse -- directed and randomized bench for codif_morse.
// The reference model works from ITU dot/dash strings, not from bit tables.
// Define CODIF_MORSE_ERR_EN to enable the err port and its checks.
module tb_codif_morse;

    logic       clk = 1'b0;
    logic       reset;
    logic       ready;
    logic [5:0] num;
    logic [4:0] morse, display, ponto, traco;
`ifdef CODIF_MORSE_ERR_EN
    logic       err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: ITU Morse strings indexed by character code.
    string itu [36] = '{
        "-----", ".----", "..---", "...--", "....-",
        ".....", "-....", "--...", "---..", "----.",
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
        ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
        "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."
    };

    logic [4:0] exp_m, exp_d, exp_p, exp_t;
    logic       exp_err;

    codif_morse dut (
        .clk     (clk),
        .reset   (reset),
        .num     (num),
        .ready   (ready),
        .morse   (morse),
        .display (display),
        .ponto   (ponto),
        .traco   (traco)
`ifdef CODIF_MORSE_ERR_EN
        ,
        .err     (err)
`endif
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        exp_m   = '0;
        exp_d   = '0;
        exp_p   = '0;
        exp_t   = '0;
        exp_err = 1'b0;
    endfunction

    function automatic void model_load(input int n);
        string s;
        exp_m   = '0;
        exp_d   = '0;
        exp_p   = '0;
        exp_t   = '0;
        exp_err = (n > 35);
        if (n <= 35) begin
            s = itu[n];
            for (int i = 0; i < s.len(); i++) begin
                exp_d[4-i] = 1'b1;
                if (s[i] == "-") begin
                    exp_m[4-i] = 1'b1;
                    exp_t[4-i] = 1'b1;
                end else begin
                    exp_p[4-i] = 1'b1;
                end
            end
        end
    endfunction

    task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Compares every output against the reference model.
    task automatic chk_all(input string tag);
        chk5({tag, "_morse"},   morse,   exp_m);
        chk5({tag, "_display"}, display, exp_d);
        chk5({tag, "_ponto"},   ponto,   exp_p);
        chk5({tag, "_traco"},   traco,   exp_t);
        chk5({tag, "_overlap"}, ponto & traco, 5'b00000);
`ifdef CODIF_MORSE_ERR_EN
        chk5({tag, "_err"}, {4'b0, err}, {4'b0, exp_err});
`endif
    endtask

    // One clock: drive the inputs on the falling edge, then sample just after the rising edge.
    task automatic step(input logic r, input logic rd, input logic [5:0] n);
        @(negedge clk);
        reset = r;
        ready = rd;
        num   = n;
        @(posedge clk);
        #1;
        if (r)       model_clear();
        else if (rd) model_load(int'(n));
        $display("step reset=%b ready=%b num=%0d -> morse=%b display=%b ponto=%b traco=%b",
                 r, rd, n, morse, display, ponto, traco);
    endtask

    initial begin
        reset = 1'b1;
        ready = 1'b0;
        num   = '0;
        model_clear();

        // reset state, and reset priority over ready
        step(1'b1, 1'b0, 6'd0);  chk_all("reset");
        step(1'b1, 1'b1, 6'd1);  chk_all("reset_over_ready");

        // digit 1
        step(1'b0, 1'b1, 6'd1);
        chk5("d1_morse", morse, 5'b01111);  chk5("d1_display", display, 5'b11111);
        chk5("d1_ponto", ponto, 5'b10000);  chk5("d1_traco", traco, 5'b01111);

        // A then E
        step(1'b0, 1'b1, 6'd10);
        chk5("A_morse", morse, 5'b01000);   chk5("A_display", display, 5'b11000);
        chk5("A_ponto", ponto, 5'b10000);   chk5("A_traco", traco, 5'b01000);
        step(1'b0, 1'b1, 6'd14);
        chk5("E_display", display, 5'b10000); chk5("E_ponto", ponto, 5'b10000);
        chk5("E_traco", traco, 5'b00000);

        // Z then 0
        step(1'b0, 1'b1, 6'd35);
        chk5("Z_morse", morse, 5'b11000);   chk5("Z_display", display, 5'b11110);
        chk5("Z_ponto", ponto, 5'b00110);   chk5("Z_traco", traco, 5'b11000);
        step(1'b0, 1'b1, 6'd0);
        chk5("d0_traco", traco, 5'b11111);  chk5("d0_ponto", ponto, 5'b00000);

        // T, then hold for three cycles while num changes
        step(1'b0, 1'b1, 6'd29);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 6'd5);
            chk5($sformatf("hold%0d_traco", k), traco, 5'b10000);
            chk5($sformatf("hold%0d_display", k), display, 5'b10000);
            chk_all($sformatf("hold%0d", k));
        end

        // invalid code, then a valid one
        step(1'b0, 1'b1, 6'd40);
        chk5("inv_morse", morse, 5'b0);     chk5("inv_display", display, 5'b0);
        chk5("inv_ponto", ponto, 5'b0);     chk5("inv_traco", traco, 5'b0);
`ifdef CODIF_MORSE_ERR_EN
        chk5("inv_err", {4'b0, err}, 5'b00001);
`endif
        step(1'b0, 1'b1, 6'd2);
        chk5("d2_ponto", ponto, 5'b11000);  chk5("d2_traco", traco, 5'b00111);
`ifdef CODIF_MORSE_ERR_EN
        chk5("d2_err", {4'b0, err}, 5'b00000);
`endif

        // back-to-back sweep with a reset in the middle
        for (int n = 0; n <= 35; n++) begin
            if (n == 20) begin
                step(1'b1, 1'b1, 6'(n));
                chk5("sweep_rst_display", display, 5'b0);
                chk5("sweep_rst_traco", traco, 5'b0);
            end else begin
                step(1'b0, 1'b1, 6'(n));
            end
            chk_all($sformatf("sweep%0d", n));
        end

        // randomized traffic
        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                 6'($urandom_range(0, 63)));
            chk_all($sformatf("rand%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
